// File: rtl/beam_timeline_engine.sv
// Streams a beam-splitter grid in CHUNK_W-bit chunks and tracks per-column beam
// multiplicities, reporting both the split count and the timeline count per puzzle.
module beam_timeline_engine #(
  parameter int CHUNK_W    = 32,
  parameter int NUM_CHUNKS = 5,
  parameter int CNT_W      = 48,
  parameter int SUM_W      = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               busy,
  output logic               result_valid,
  output logic [SUM_W-1:0]   split_count,
  output logic [SUM_W-1:0]   timeline_count
);

  localparam int COLS   = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int POP_W  = $clog2(COLS + 1);
  localparam int CSUM_W = CNT_W + $clog2(CHUNK_W + 1);
  localparam int ACC_W  = ((SUM_W > CSUM_W) ? SUM_W : CSUM_W) + 1;
  localparam int ROW_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {LOAD, UPDATE, SUM, DONE} state_t;
  state_t state_reg, state_next;

  logic [IDX_W-1:0]                      chunk_idx_reg, sum_idx_reg;
  logic [ROW_W-1:0]                      row_idx_reg;
  logic                                  last_row_reg;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    row_buf_reg;
  logic [COLS-1:0]                       row_bits;
  logic [COLS-1:0][CNT_W-1:0]            cnt_reg, cnt_next;
  logic [COLS-1:0]                       split_hit;
  logic [SUM_W-1:0]                      split_acc_reg, tl_acc_reg;
  logic [POP_W-1:0]                      split_pop;
  logic [SUM_W:0]                        split_sum;
  logic [SUM_W-1:0]                      split_sat;
  logic [CSUM_W-1:0]                     chunk_sum [NUM_CHUNKS];
  logic [ACC_W-1:0]                      tl_sum;
  logic [SUM_W-1:0]                      tl_sat;
  logic                                  transfer, last_chunk;

  assign in_ready   = (state_reg == LOAD);
  assign transfer   = in_valid && in_ready;
  assign last_chunk = (chunk_idx_reg == LAST_IDX);
  assign row_bits   = row_buf_reg;

  // Each column pulls from itself (if no splitter) and from splitting neighbours.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [CNT_W+1:0] stay, from_left, from_right, total;
    assign stay = row_bits[gi] ? '0 : {2'b00, cnt_reg[gi]};
    if (gi > 0) begin : g_left
      assign from_left = row_bits[gi-1] ? {2'b00, cnt_reg[gi-1]} : '0;
    end else begin : g_left_edge
      assign from_left = '0;
    end
    if (gi < COLS - 1) begin : g_right
      assign from_right = row_bits[gi+1] ? {2'b00, cnt_reg[gi+1]} : '0;
    end else begin : g_right_edge
      assign from_right = '0;
    end
    assign total = stay + from_left + from_right;
    assign cnt_next[gi] = (row_idx_reg == '0) ? {{(CNT_W-1){1'b0}}, row_bits[gi]} :
                          (total > {2'b00, CNT_MAX}) ? CNT_MAX : total[CNT_W-1:0];
    assign split_hit[gi] = row_bits[gi] && (cnt_reg[gi] != '0);
  end

  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    always_comb begin
      chunk_sum[gi] = '0;
      for (int i = 0; i < CHUNK_W; i++)
        chunk_sum[gi] = chunk_sum[gi] + CSUM_W'(cnt_reg[gi*CHUNK_W + i]);
    end
  end

  always_comb begin
    split_pop = '0;
    for (int i = 0; i < COLS; i++)
      split_pop = split_pop + POP_W'(split_hit[i]);
  end

  assign split_sum = {1'b0, split_acc_reg} + (SUM_W+1)'(split_pop);
  assign split_sat = split_sum[SUM_W] ? SUM_MAX : split_sum[SUM_W-1:0];
  assign tl_sum    = ACC_W'(tl_acc_reg) + ACC_W'(chunk_sum[sum_idx_reg]);
  assign tl_sat    = (tl_sum > ACC_W'(SUM_MAX)) ? SUM_MAX : tl_sum[SUM_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= LOAD;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (transfer && last_chunk) state_next = UPDATE;
      UPDATE:  state_next = last_row_reg ? SUM : LOAD;
      SUM:     if (sum_idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_idx_reg  <= '0;
      sum_idx_reg    <= '0;
      row_idx_reg    <= '0;
      last_row_reg   <= 1'b0;
      row_buf_reg    <= '0;
      cnt_reg        <= '0;
      split_acc_reg  <= '0;
      tl_acc_reg     <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      split_count    <= '0;
      timeline_count <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state_reg)
        LOAD: if (transfer) begin
          row_buf_reg[chunk_idx_reg] <= in_data;
          busy <= 1'b1;
          if (last_chunk) begin
            chunk_idx_reg <= '0;
            last_row_reg  <= in_last;
          end else begin
            chunk_idx_reg <= chunk_idx_reg + IDX_W'(1);
          end
        end
        UPDATE: begin
          cnt_reg <= cnt_next;
          if (row_idx_reg != '0) split_acc_reg <= split_sat;
          // Saturating so a very tall grid never wraps back into seed-row behaviour.
          if (row_idx_reg != '1) row_idx_reg <= row_idx_reg + ROW_W'(1);
        end
        SUM: begin
          tl_acc_reg  <= tl_sat;
          sum_idx_reg <= (sum_idx_reg == LAST_IDX) ? '0 : sum_idx_reg + IDX_W'(1);
        end
        DONE: begin
          result_valid   <= 1'b1;
          split_count    <= split_acc_reg;
          timeline_count <= tl_acc_reg;
          busy           <= 1'b0;
          cnt_reg        <= '0;
          split_acc_reg  <= '0;
          tl_acc_reg     <= '0;
          row_idx_reg    <= '0;
          chunk_idx_reg  <= '0;
          sum_idx_reg    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/beam_timeline_engine.md
# beam_timeline_engine

Parametrised successor to the chunked beam/splitter counter: consumes a manifold grid as a stream of CHUNK_W-bit chunks, NUM_CHUNKS chunks per row. It tracks per-column beam multiplicities, so one pass yields both the split count (part 1) and the timeline count (part 2). It sits between the row-chunk input stream and the result reporting logic, and replaces the fixed 32×5, split-count-only block.

## Interface
- CHUNK_W, 32: bits per input chunk.
- NUM_CHUNKS, 5: chunks per grid row; COLS = CHUNK_W*NUM_CHUNKS.
- CNT_W, 48: per-column timeline counter width (saturating).
- SUM_W, 64: width of split_count and timeline_count (saturating).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  chunk valid.
- in_ready  out  1  block can accept a chunk; a transfer occurs when in_valid && in_ready.
- in_data  in  CHUNK_W  chunk; bit i of chunk k is column k*CHUNK_W+i; column 0 is leftmost.
- in_last  in  1  marks the final row; sampled only on a row's final chunk.
- busy  out  1  puzzle in progress: at least one chunk accepted and result not yet delivered.
- result_valid  out  1  one-cycle pulse; results are updated in this cycle.
- split_count  out  SUM_W  total splits of the last completed puzzle.
- timeline_count  out  SUM_W  total timelines of the last completed puzzle.

## Operation
- FSM states: LOAD, UPDATE, SUM, DONE. Reset state is LOAD.
- Reset values: in_ready=1, busy=0, result_valid=0, split_count=0, timeline_count=0. All column counters, the row buffer, chunk_idx, row_idx and accumulators are 0.
- LOAD:
  - Each transfer writes in_data into row-buffer slot chunk_idx, then increments chunk_idx.
  - On the transfer at chunk_idx==NUM_CHUNKS-1: chunk_idx wraps to 0, in_last is captured as last_row, and the FSM goes to UPDATE.
  - in_last on any other chunk is ignored.
- UPDATE (1 cycle, in_ready=0): let cnt[c] be the column counters, s[c] the row buffer, and active[c] = (cnt[c]!=0).
  - Row 0 (seed row): cnt[c] = s[c] ? 1 : 0. No splits are counted.
  - Rows ≥1, next-state: cnt'[c] = (s[c] ? 0 : cnt[c]) + (s[c-1] ? cnt[c-1] : 0) + (s[c+1] ? cnt[c+1] : 0).
  - Terms for out-of-range columns (-1, COLS) are 0, so flows off the grid edge are dropped.
  - The sum is saturated at 2^CNT_W-1.
  - split_acc += popcount(active & s), saturated at 2^SUM_W-1.
  - row_idx increments. If last_row, go to SUM; otherwise go to LOAD.
- SUM (NUM_CHUNKS cycles, in_ready=0): cycle j adds cnt[j*CHUNK_W .. j*CHUNK_W+CHUNK_W-1], zero-extended, to tl_acc, saturating at 2^SUM_W-1.
- DONE (1 cycle, in_ready=0):
  - result_valid=1; split_count<=split_acc and timeline_count<=tl_acc.
  - All cnt, accumulators, row_idx and chunk_idx are cleared. Next state is LOAD.
- Outputs hold their values until the next DONE.
- A single-row puzzle (seed row with in_last) is legal: splits=0, timelines = popcount(seed).
- Reset mid-operation aborts the puzzle immediately and returns every register to its reset value. Partial rows are discarded.

## Timing
- Throughput: NUM_CHUNKS+1 cycles per row. in_ready is low for exactly the one UPDATE cycle after each row's final transfer.
- Edge E accepts the final chunk of the final row. Then:
  - UPDATE completes at E+1.
  - SUM completes at E+1+NUM_CHUNKS.
  - result_valid is high in the cycle after that edge (registered outputs), i.e. NUM_CHUNKS+2 cycles after E.
  - in_ready rises after DONE.
- busy rises the cycle after the first accepted chunk and falls in the same cycle result_valid rises.
- in_data/in_last must be held while in_valid=1 and in_ready=0. The block takes no data during stall cycles.

## Test plan
Parameters for all tests: CHUNK_W=4, NUM_CHUNKS=2. Chunks are listed as (chunk0, chunk1).

- **Basic, crosses chunk boundary:**
  - Stimulus: seed (4'b1000, 0); row1 (4'b1000, 0); row2 (4'b0100, 4'b0001) with in_last.
  - Required: result_valid 4 cycles after the last accept; split_count=3, timeline_count=4.
- **Edge drop:**
  - Stimulus: seed (4'b0001, 0); row1 (4'b0001, 0) with last.
  - Required: split_count=1, timeline_count=1.
- **Saturation, CNT_W=2:**
  - Stimulus: seed col3; splitter rows {3}, {2,4}, {1,3,5}, {2,4}; last.
  - Required: split_count=8, timeline_count=11. Column 3 saturates at 3 (14 if unsaturated).
- **Backpressure:**
  - Stimulus: in_valid held high continuously through the basic-test stream.
  - Required: in_ready=0 exactly one cycle after each row, no chunk lost or duplicated, same results as the basic test.
- **Reset mid-row:**
  - Stimulus: accept one chunk, pulse reset, then replay the basic test.
  - Required: outputs read 0 during and after reset; final results 3/4.
- **Single-row and back-to-back puzzles:**
  - Stimulus: seed (4'b0001, 4'b1000) with last, then the basic test immediately after.
  - Required: first result 0/2, second result 3/4 (no carry-over of state between puzzles).
